// File: rtl/gpio_ctrl_n_pkg.sv
// Shared definitions for the GPIO controller: register offsets, pin modes and
// the per-pin pad-drive decode.
package gpio_ctrl_n_pkg;

   localparam logic [7:0] GPIO_MODE0 = 8'h00;
   localparam logic [7:0] GPIO_MODE1 = 8'h04;
   localparam logic [7:0] GPIO_DOUT  = 8'h08;
   localparam logic [7:0] GPIO_DIN   = 8'h0C;
   localparam logic [7:0] GPIO_IRISE = 8'h10;
   localparam logic [7:0] GPIO_IFALL = 8'h14;
   localparam logic [7:0] GPIO_ISTAT = 8'h18;
   localparam logic [7:0] GPIO_DBCNT = 8'h1C;

   localparam int unsigned GPIO_PINS_PER_MODE = 16;

   typedef enum logic [1:0] {
      ModeIn    = 2'b00,
      ModePp    = 2'b01,
      ModeOd    = 2'b10,
      ModeInAlt = 2'b11
   } gpio_mode_e;

   // Returns {oe, out} for one pad.
   function automatic logic [1:0] pad_drive(gpio_mode_e mode, logic dout);
      case (mode)
         ModePp:  return {1'b1, dout};
         ModeOd:  return {~dout, 1'b0};
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/gpio_ctrl_n_pin_filter.sv
// Per-pin input path: 2-flop synchroniser, tick-qualified debounce and
// rise/fall detection on the filtered value.
module gpio_ctrl_n_pin_filter (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   input  logic tick_i,
   input  logic bypass_i,
   input  logic clr_i,
   output logic filt_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q, sync2_q;
   logic samp_q, samp_d;
   logic filt_q, filt_d;
   logic filt_dly_q;

   always_comb begin
      samp_d = samp_q;
      filt_d = filt_q;
      if (clr_i) begin
         samp_d = 1'b0;
      end else if (tick_i) begin
         samp_d = sync2_q;
      end
      // A new level is accepted only when two consecutive ticks agree.
      if (bypass_i) begin
         filt_d = sync2_q;
      end else if (tick_i && !clr_i && (sync2_q == samp_q)) begin
         filt_d = sync2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         samp_q     <= 1'b0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
      end else begin
         sync1_q    <= pin_i;
         sync2_q    <= sync1_q;
         samp_q     <= samp_d;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
      end
   end

   assign filt_o = filt_q;
   assign rise_o = filt_q & ~filt_dly_q;
   assign fall_o = ~filt_q & filt_dly_q;

endmodule

// File: rtl/gpio_ctrl_n.sv
// Parametrised GPIO controller on the rib bus: register file, read mux,
// debounce prescaler, edge interrupts and pad-drive decode.
module gpio_ctrl_n
   import gpio_ctrl_n_pkg::*;
#(
   parameter int unsigned NPINS = 16,
   parameter int unsigned DB_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      data_i,
   output logic [31:0]      data_o,
   input  logic [NPINS-1:0] io_pin_i,
   output logic [NPINS-1:0] io_oe_o,
   output logic [NPINS-1:0] io_out_o,
   output logic             irq_o
);

   logic [NPINS-1:0][1:0] mode_q, mode_d;
   logic [NPINS-1:0]      dout_q, dout_d, irise_q, irise_d, ifall_q, ifall_d;
   logic [NPINS-1:0]      istat_q, istat_d;
   logic [DB_W-1:0]       dbcnt_q, dbcnt_d, presc_q, presc_d;
   logic                  irq_q;
   logic [NPINS-1:0]      din, rise, fall;
   logic [31:0]           mode0_rd, mode1_rd;
   logic                  wr_mode0, wr_mode1, wr_dout, wr_irise, wr_ifall, wr_istat, wr_dbcnt;
   logic                  tick, bypass;
   logic                  unused_addr;

   assign unused_addr = ^addr_i[31:8];

   assign wr_mode0 = we_i && (addr_i[7:0] == GPIO_MODE0);
   assign wr_mode1 = we_i && (addr_i[7:0] == GPIO_MODE1);
   assign wr_dout  = we_i && (addr_i[7:0] == GPIO_DOUT);
   assign wr_irise = we_i && (addr_i[7:0] == GPIO_IRISE);
   assign wr_ifall = we_i && (addr_i[7:0] == GPIO_IFALL);
   assign wr_istat = we_i && (addr_i[7:0] == GPIO_ISTAT);
   assign wr_dbcnt = we_i && (addr_i[7:0] == GPIO_DBCNT);

   // Tick is suppressed on a DBCNT write so the restarted count is clean.
   assign bypass = (dbcnt_q == '0);
   assign tick   = !bypass && (presc_q == dbcnt_q) && !wr_dbcnt;

   always_comb begin
      mode_d  = mode_q;
      dout_d  = wr_dout  ? data_i[NPINS-1:0] : dout_q;
      irise_d = wr_irise ? data_i[NPINS-1:0] : irise_q;
      ifall_d = wr_ifall ? data_i[NPINS-1:0] : ifall_q;
      dbcnt_d = wr_dbcnt ? data_i[DB_W-1:0]  : dbcnt_q;
      for (int i = 0; i < NPINS; i++) begin
         if ((i < GPIO_PINS_PER_MODE) ? wr_mode0 : wr_mode1) begin
            mode_d[i] = data_i[2*(i % GPIO_PINS_PER_MODE) +: 2];
         end
      end
      // Set wins over a simultaneous W1C.
      istat_d = (istat_q & ~(wr_istat ? data_i[NPINS-1:0] : '0))
              | (rise & irise_q) | (fall & ifall_q);
      if (wr_dbcnt || bypass || (presc_q == dbcnt_q)) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= '0;
         dout_q  <= '0;
         irise_q <= '0;
         ifall_q <= '0;
         istat_q <= '0;
         dbcnt_q <= '0;
         presc_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         dout_q  <= dout_d;
         irise_q <= irise_d;
         ifall_q <= ifall_d;
         istat_q <= istat_d;
         dbcnt_q <= dbcnt_d;
         presc_q <= presc_d;
         irq_q   <= |istat_q;
      end
   end

   for (genvar g = 0; g < NPINS; g++) begin : g_pin
      gpio_ctrl_n_pin_filter u_filter (
         .clk      (clk),
         .rst      (rst),
         .pin_i    (io_pin_i[g]),
         .tick_i   (tick),
         .bypass_i (bypass),
         .clr_i    (wr_dbcnt),
         .filt_o   (din[g]),
         .rise_o   (rise[g]),
         .fall_o   (fall[g])
      );
   end

   always_comb begin
      io_oe_o  = '0;
      io_out_o = '0;
      mode0_rd = '0;
      mode1_rd = '0;
      for (int i = 0; i < NPINS; i++) begin
         {io_oe_o[i], io_out_o[i]} = pad_drive(gpio_mode_e'(mode_q[i]), dout_q[i]);
         if (i < GPIO_PINS_PER_MODE) begin
            mode0_rd[2*(i % GPIO_PINS_PER_MODE) +: 2] = mode_q[i];
         end else begin
            mode1_rd[2*(i % GPIO_PINS_PER_MODE) +: 2] = mode_q[i];
         end
      end
   end

   always_comb begin
      data_o = '0;
      case (addr_i[7:0])
         GPIO_MODE0: data_o = mode0_rd;
         GPIO_MODE1: data_o = mode1_rd;
         GPIO_DOUT:  data_o = 32'(dout_q);
         GPIO_DIN:   data_o = 32'(din);
         GPIO_IRISE: data_o = 32'(irise_q);
         GPIO_IFALL: data_o = 32'(ifall_q);
         GPIO_ISTAT: data_o = 32'(istat_q);
         GPIO_DBCNT: data_o = 32'(dbcnt_q);
         default:    data_o = '0;
      endcase
   end

   assign irq_o = irq_q;

endmodule
